// File: rtl/ptltx_arb_pkg.sv
// ptltx_arb_pkg: shared types, default sizes and helpers for the PTL transmitter arbiter.
package ptltx_arb_pkg;
    typedef enum logic {IDLE, GUARD} state_t;
    localparam int DEF_N_REQ   = 4;
    localparam int DEF_CNT_W   = 4;
    localparam int DEF_GAP_CYC = 2;
    function automatic int guard_w(input int gap);
        return $clog2(gap + 1);
    endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin picker, searching from ptr+1 upward with wrap.
module rr_picker #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          valid
);
    logic [PW-1:0] idx;
    // Walk offsets from farthest to nearest so the nearest requester after ptr wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = N; k >= 1; k--) begin
            idx = PW'((int'(ptr) + k) % N);
            if (req[idx]) gnt = N'(1) << idx;
        end
    end
    assign valid = |req;
endmodule

// File: rtl/ptltx_arbiter.sv
// ptltx_arbiter: round-robin scheduler driving one PTLTX toggle input with a
// guaranteed guard gap after every issued pulse.
module ptltx_arbiter
    import ptltx_arb_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int GAP_CYC = DEF_GAP_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic             ovf_clr,
    output logic             tx_a,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] pending,
    output logic [N_REQ-1:0] ovf,
    output logic             busy
);
    localparam int PW = $clog2(N_REQ);
    localparam int GW = guard_w(GAP_CYC);

    state_t           state, state_nx;
    logic [GW-1:0]    gcnt, gcnt_nx;
    logic [PW-1:0]    ptr, win_idx;
    logic [N_REQ-1:0] win, iss, ovf_set;
    logic             win_v, issue;
    logic [CNT_W-1:0] cnt    [N_REQ];
    logic [CNT_W-1:0] cnt_nx [N_REQ];

    rr_picker #(.N(N_REQ), .PW(PW)) u_pick (
        .req   (pending),
        .ptr   (ptr),
        .gnt   (win),
        .valid (win_v)
    );

    always_comb begin
        issue    = state == IDLE && en && win_v;
        iss      = issue ? win : '0;
        state_nx = issue ? GUARD : (state == GUARD && gcnt == GW'(1)) ? IDLE : state;
        gcnt_nx  = issue ? GW'(GAP_CYC) : state == GUARD ? gcnt - GW'(1) : gcnt;
        win_idx  = '0;
        for (int i = 0; i < N_REQ; i++)
            if (win[i]) win_idx = PW'(i);
    end

    // A request landing on a saturated, ungranted counter is dropped and flagged.
    always_comb begin
        pending = '0;
        ovf_set = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pending[i] = |cnt[i];
            ovf_set[i] = req[i] && !iss[i] && &cnt[i];
            cnt_nx[i]  = ovf_set[i] ? cnt[i] :
                         (req[i] && !iss[i]) ? cnt[i] + CNT_W'(1) :
                         (iss[i] && !req[i]) ? cnt[i] - CNT_W'(1) : cnt[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gcnt  <= '0;
            ptr   <= PW'(N_REQ - 1);
            tx_a  <= 1'b0;
            grant <= '0;
            ovf   <= '0;
            cnt   <= '{default: '0};
        end else begin
            state <= state_nx;
            gcnt  <= gcnt_nx;
            ptr   <= issue ? win_idx : ptr;
            tx_a  <= tx_a ^ issue;
            grant <= iss;
            ovf   <= (ovf & ~{N_REQ{ovf_clr}}) | ovf_set;
            cnt   <= cnt_nx;
        end
    end

    assign busy = state == GUARD;
endmodule

// File: tb/tb_ptltx_arbiter.sv
// tb_ptltx_arbiter: scoreboard bench; stimulus queues expected grants, a negedge monitor checks them.
module tb_ptltx_arbiter;
    logic       clk = 0, rst_n = 0, en = 1, ovf_clr = 0;
    logic [3:0] req = 0;
    logic       tx_a, busy;
    logic [3:0] grant, pending, ovf;
    int         cyc = 0, tests = 0, fails = 0;
    logic       exp_tx = 0;

    typedef struct { int c; logic [3:0] g; logic tx; } exp_t;
    exp_t sb[$];

    ptltx_arbiter #(.N_REQ(4), .CNT_W(2), .GAP_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .ovf_clr(ovf_clr),
        .tx_a(tx_a), .grant(grant), .pending(pending), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_grant(input int c, input logic [3:0] g);
        exp_tx = ~exp_tx;
        sb.push_back('{c: c, g: g, tx: exp_tx});
    endtask

    always @(negedge clk) begin
        if (grant !== 4'b0) begin
            if (sb.size() == 0) begin
                chk("unexpected_grant", {28'b0, grant}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("grant_vec", {28'b0, grant}, {28'b0, e.g});
                chk("grant_cycle", cyc, e.c);
                chk("tx_a_at_grant", {31'b0, tx_a}, {31'b0, e.tx});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        tick(3);
        chk("rst_tx_a", {31'b0, tx_a}, 0);
        chk("rst_grant", {28'b0, grant}, 0);
        chk("rst_pending", {28'b0, pending}, 0);
        chk("rst_ovf", {28'b0, ovf}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        rst_n = 1;
        tick(2);

        // single request: pending next cycle, grant two cycles later, busy for two cycles
        c = cyc;
        req = 4'b0100;
        expect_grant(c + 2, 4'b0100);
        tick();
        req = 0;
        chk("single_pending", {28'b0, pending}, 32'b0100);
        chk("single_busy_pre", {31'b0, busy}, 0);
        tick();
        chk("single_pending_drop", {28'b0, pending}, 0);
        chk("single_busy1", {31'b0, busy}, 1);
        tick();
        chk("single_busy2", {31'b0, busy}, 1);
        tick();
        chk("single_busy_end", {31'b0, busy}, 0);
        tick(3);

        // full backlog rotation from a fresh pointer
        rst_n = 0;
        exp_tx = 0;
        tick();
        rst_n = 1;
        tick();
        c = cyc;
        req = 4'b1111;
        for (int k = 0; k < 12; k++) expect_grant(c + 2 + 3 * k, 4'b0001 << (k % 4));
        tick(3);
        req = 0;
        tick(38);
        chk("backlog_drained", {28'b0, pending}, 0);
        chk("backlog_no_ovf", {28'b0, ovf}, 0);
        chk("backlog_sb_empty", sb.size(), 0);

        // overflow with issue disabled, then clear vs. simultaneous set
        en = 0;
        req = 4'b0010;
        tick(5);
        req = 0;
        chk("ovf_set", {28'b0, ovf}, 32'b0010);
        chk("ovf_pending", {28'b0, pending}, 32'b0010);
        ovf_clr = 1;
        tick();
        ovf_clr = 0;
        chk("ovf_cleared", {28'b0, ovf}, 0);
        ovf_clr = 1;
        req = 4'b0010;
        tick();
        ovf_clr = 0;
        req = 0;
        chk("ovf_set_wins", {28'b0, ovf}, 32'b0010);
        ovf_clr = 1;
        tick();
        ovf_clr = 0;
        chk("ovf_cleared2", {28'b0, ovf}, 0);

        // en gating: drop en during guard, restore later
        c = cyc;
        en = 1;
        expect_grant(c + 1, 4'b0010);
        tick();
        en = 0;
        tick(4);
        chk("gate_pending_held", {28'b0, pending}, 32'b0010);
        chk("gate_idle", {31'b0, busy}, 0);
        tick();
        en = 1;
        expect_grant(c + 7, 4'b0010);
        tick();
        expect_grant(c + 10, 4'b0010);
        tick(6);
        chk("gate_drained", {28'b0, pending}, 0);

        // request coinciding with its own issue keeps the count
        c = cyc;
        req = 4'b0001;
        expect_grant(c + 2, 4'b0001);
        tick();
        tick();
        req = 0;
        chk("simul_count_kept", {28'b0, pending}, 32'b0001);
        expect_grant(c + 5, 4'b0001);
        tick(6);
        chk("simul_drained", {28'b0, pending}, 0);

        // reset with queued pulses and tx_a high
        en = 0;
        req = 4'b0111;
        tick();
        req = 0;
        chk("pre_rst_pending", {28'b0, pending}, 32'b0111);
        chk("pre_rst_tx_a", {31'b0, tx_a}, 1);
        rst_n = 0;
        exp_tx = 0;
        #1;
        chk("mid_rst_tx_a", {31'b0, tx_a}, 0);
        chk("mid_rst_grant", {28'b0, grant}, 0);
        chk("mid_rst_pending", {28'b0, pending}, 0);
        chk("mid_rst_busy", {31'b0, busy}, 0);
        tick();
        rst_n = 1;
        en = 1;
        tick(10);
        chk("post_rst_quiet", {31'b0, tx_a}, 0);
        chk("final_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
